// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with runtime frame format (5..DATA_WIDTH data
// bits, optional even/odd parity, 1 or 2 stop bits), false-start and break
// detection, and a first-word-fall-through FIFO of tagged frames with a sticky
// overrun flag.
// Optional feature macro: UART_RX_MAJORITY_EN (3-sample majority vote per bit
// when the latched divider is at least 4).
// Debug: state_o exposes the receiver FSM state
// (0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 BRK_WAIT).
// Handshake: valid_o is high while the FIFO holds a frame; the head fields are
// meaningful only then. A pop happens on a clock edge where read_i and valid_o
// are both high; read_i while valid_o is low has no effect.
module uart_rx_fifo #(
  parameter int CLOCK_DIVIDER_WIDTH = 16,
  parameter int DATA_WIDTH          = 9,
  parameter int FIFO_DEPTH_LOG2     = 2
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           serial_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic [3:0]                     data_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  input  logic                           two_stop_bits_i,
  input  logic                           read_i,
  input  logic                           clear_errors_i,
  output logic [DATA_WIDTH-1:0]          data_o,
  output logic                           valid_o,
  output logic                           parity_error_o,
  output logic                           framing_error_o,
  output logic                           break_o,
  output logic                           overrun_o,
  output logic [FIFO_DEPTH_LOG2:0]       fifo_count_o,
  output logic [2:0]                     state_o
);

  localparam int CDW   = CLOCK_DIVIDER_WIDTH;
  localparam int FW    = DATA_WIDTH + 3;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam logic [3:0]               MAX_BITS = 4'(DATA_WIDTH);
  localparam logic [CDW-1:0]           T_ONE    = CDW'(1);
  localparam logic [CDW-1:0]           T_TWO    = CDW'(2);
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
  localparam logic [FIFO_DEPTH_LOG2:0] CNT_FULL = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE = FIFO_DEPTH_LOG2'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
    S_PARITY   = 3'd3,
    S_STOP     = 3'd4,
    S_BRK_WAIT = 3'd5
  } state_t;

  state_t                    state;
  logic                      rx_meta, rxs;
  logic [CDW-1:0]            timer, div_q, half;
  logic [3:0]                nbits_q, nbits_in, bit_cnt;
  logic                      par_en_q, par_even_q, two_stop_q, stop_cnt;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_acc, all_zero, perr_q, ferr_q, brk_q;
  logic                      start_accept, in_frame, sample_tick, sample_val;
  logic                      push, push_brk, push_ferr, push_ok, pop, full;
  logic [FW-1:0]             push_word, head;
  logic [FW-1:0]             mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]  count;

  // Two-flop synchroniser for the asynchronous RX line, idle high.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= serial_i;
      rxs     <= rx_meta;
    end
  end

  // Clamp the requested data-bit count into 5..DATA_WIDTH.
  always_comb begin
    nbits_in = data_bits_i;
    if (data_bits_i < 4'd5)          nbits_in = 4'd5;
    else if (data_bits_i > MAX_BITS) nbits_in = MAX_BITS;
  end

  assign half         = div_q >> 1;
  assign start_accept = (state == S_IDLE) && !rxs && (clock_divider_i >= T_TWO);
  assign in_frame     = (state == S_START) || (state == S_DATA) ||
                        (state == S_PARITY) || (state == S_STOP);

`ifdef UART_RX_MAJORITY_EN
  logic maj_en_q, s_early, s_mid;

  // Capture the two early votes and remember whether voting is allowed.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      maj_en_q <= 1'b0;
      s_early  <= 1'b1;
      s_mid    <= 1'b1;
    end else begin
      if (start_accept) maj_en_q <= (clock_divider_i >= CDW'(4));
      if (timer == half + T_ONE) s_early <= rxs;
      if (timer == half)         s_mid   <= rxs;
    end
  end

  // Decide on the third vote when voting, otherwise on the single mid sample.
  always_comb begin
    if (maj_en_q) begin
      sample_tick = in_frame && (timer == half - T_ONE);
      sample_val  = (s_early & s_mid) | (s_early & rxs) | (s_mid & rxs);
    end else begin
      sample_tick = in_frame && (timer == half);
      sample_val  = rxs;
    end
  end
`else
  // Single sample at the bit centre.
  always_comb begin
    sample_tick = in_frame && (timer == half);
    sample_val  = rxs;
  end
`endif

  // Commit happens on the final stop-bit sample; break is judged on stop 1.
  always_comb begin
    push      = (state == S_STOP) && sample_tick && (!two_stop_q || stop_cnt);
    push_brk  = stop_cnt ? brk_q : (all_zero && !sample_val);
    push_ferr = ferr_q | ~sample_val;
    push_word = {push_brk, push_ferr, perr_q, push_brk ? '0 : data_q};
  end

  // Receiver FSM: bit timer, frame configuration latch and field assembly.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state      <= S_IDLE;
      timer      <= '0;
      div_q      <= '0;
      nbits_q    <= 4'd5;
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
      two_stop_q <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      data_q     <= '0;
      par_acc    <= 1'b0;
      all_zero   <= 1'b1;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      brk_q      <= 1'b0;
    end else begin
      if (in_frame) timer <= (timer == '0) ? div_q - T_ONE : timer - T_ONE;
      unique case (state)
        S_IDLE: begin
          if (start_accept) begin
            state      <= S_START;
            timer      <= clock_divider_i - T_ONE;
            div_q      <= clock_divider_i;
            nbits_q    <= nbits_in;
            par_en_q   <= parity_bit_i;
            par_even_q <= parity_even_i;
            two_stop_q <= two_stop_bits_i;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            data_q     <= '0;
            par_acc    <= 1'b0;
            all_zero   <= 1'b1;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            brk_q      <= 1'b0;
          end
        end
        S_START: begin
          if (sample_tick) state <= sample_val ? S_IDLE : S_DATA;
        end
        S_DATA: begin
          if (sample_tick) begin
            data_q   <= data_q | (DATA_WIDTH'(sample_val) << bit_cnt);
            par_acc  <= par_acc ^ sample_val;
            all_zero <= all_zero & ~sample_val;
            bit_cnt  <= bit_cnt + 4'd1;
            if (bit_cnt == nbits_q - 4'd1) state <= par_en_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (sample_tick) begin
            perr_q   <= par_acc ^ sample_val ^ ~par_even_q;
            all_zero <= all_zero & ~sample_val;
            state    <= S_STOP;
          end
        end
        S_STOP: begin
          if (sample_tick) begin
            ferr_q <= push_ferr;
            if (!stop_cnt) brk_q <= all_zero & ~sample_val;
            if (push) state <= push_brk ? S_BRK_WAIT : S_IDLE;
            else      stop_cnt <= 1'b1;
          end
        end
        S_BRK_WAIT: begin
          if (rxs) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign full    = (count == CNT_FULL);
  assign pop     = read_i && (count != '0);
  assign push_ok = push && (!full || pop);

  // FIFO storage; contents are only observed through valid entries.
  always_ff @(posedge clock_i) begin
    if (push_ok) mem[wr_ptr] <= push_word;
  end

  // FIFO pointers, occupancy and sticky overrun (set beats clear).
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (!push_ok && pop) count <= count - CNT_ONE;
      if (push && full && !pop) overrun_o <= 1'b1;
      else if (clear_errors_i)  overrun_o <= 1'b0;
    end
  end

  assign head            = mem[rd_ptr];
  assign valid_o         = (count != '0);
  assign data_o          = valid_o ? head[DATA_WIDTH-1:0] : '0;
  assign parity_error_o  = valid_o & head[DATA_WIDTH];
  assign framing_error_o = valid_o & head[DATA_WIDTH+1];
  assign break_o         = valid_o & head[DATA_WIDTH+2];
  assign fifo_count_o    = count;
  assign state_o         = state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: directed frame table, break/overrun/glitch/
// reset/spike sequences, and randomized frames against a frame-level model.
module tb_uart_rx_fifo;

  localparam int CDW = 16;
  localparam int DW  = 9;
  localparam int FL2 = 2;
  localparam int FW  = DW + 3;

  logic           clock_i = 1'b0;
  logic           reset_i;
  logic           serial_i;
  logic [CDW-1:0] clock_divider_i;
  logic [3:0]     data_bits_i;
  logic           parity_bit_i, parity_even_i, two_stop_bits_i;
  logic           read_i, clear_errors_i;
  logic [DW-1:0]  data_o;
  logic           valid_o, parity_error_o, framing_error_o, break_o, overrun_o;
  logic [FL2:0]   fifo_count_o;
  logic [2:0]     state_o;

  uart_rx_fifo #(.CLOCK_DIVIDER_WIDTH(CDW), .DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(FL2)) dut (
    .clock_i(clock_i), .reset_i(reset_i), .serial_i(serial_i),
    .clock_divider_i(clock_divider_i), .data_bits_i(data_bits_i),
    .parity_bit_i(parity_bit_i), .parity_even_i(parity_even_i),
    .two_stop_bits_i(two_stop_bits_i), .read_i(read_i), .clear_errors_i(clear_errors_i),
    .data_o(data_o), .valid_o(valid_o), .parity_error_o(parity_error_o),
    .framing_error_o(framing_error_o), .break_o(break_o), .overrun_o(overrun_o),
    .fifo_count_o(fifo_count_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];
  bit line_q[$];

  typedef struct {
    int div; int nbits; bit par_en; bit even; bit two; int data; bit flip;
    bit stop1; bit stop2;
    int e_data; bit e_perr; bit e_ferr; bit e_brk;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int clamp_bits(input int n);
    if (n < 5) return 5;
    if (n > DW) return DW;
    return n;
  endfunction

  // Parity bit that makes the frame correct for the chosen sense.
  function automatic bit good_parity(input int d, input bit even);
    int ones;
    ones = $countones(d);
    return even ? bit'(ones % 2) : bit'(1 - ones % 2);
  endfunction

  // Frame-level reference: what the receiver should report for a sent frame.
  function automatic logic [FW-1:0] model_word(input int nbits, input bit par_en,
      input bit even, input bit two, input int data, input bit flip,
      input bit stop1, input bit stop2);
    int n, d, ones;
    bit pbit, perr, ferr, brk;
    n    = clamp_bits(nbits);
    d    = data & ((1 << n) - 1);
    pbit = good_parity(d, even) ^ flip;
    ones = $countones(d) + (par_en ? int'(pbit) : 0);
    perr = par_en && (even ? (ones % 2 == 1) : (ones % 2 == 0));
    ferr = !stop1 || (two && !stop2);
    brk  = (d == 0) && (!par_en || !pbit) && !stop1;
    return {brk, ferr, perr, DW'(brk ? 0 : d)};
  endfunction

  task automatic build_frame(input int nbits, input bit par_en, input bit even,
      input bit two, input int data, input bit flip, input bit stop1, input bit stop2);
    int n;
    n = clamp_bits(nbits);
    line_q.delete();
    line_q.push_back(1'b0);
    for (int i = 0; i < n; i++) line_q.push_back(bit'((data >> i) & 1));
    if (par_en) line_q.push_back(good_parity(data & ((1 << n) - 1), even) ^ flip);
    line_q.push_back(stop1);
    if (two) line_q.push_back(stop2);
  endtask

  // driver: each line bit held for div cycles; optional one-cycle spike.
  task automatic drive_line(input int div, input int max_bits, input int spike_bit,
      input int spike_off);
    int nb;
    nb = (max_bits < 0 || max_bits > line_q.size()) ? line_q.size() : max_bits;
    for (int b = 0; b < nb; b++)
      for (int c = 0; c < div; c++) begin
        serial_i = (b == spike_bit && c == spike_off) ? ~line_q[b] : line_q[b];
        @(negedge clock_i);
      end
  endtask

  task automatic set_cfg(input int div, input int nbits, input bit par_en,
      input bit even, input bit two);
    clock_divider_i = CDW'(div);
    data_bits_i     = 4'(nbits);
    parity_bit_i    = par_en;
    parity_even_i   = even;
    two_stop_bits_i = two;
  endtask

  task automatic send(input int div, input int nbits, input bit par_en, input bit even,
      input bit two, input int data, input bit flip, input bit stop1, input bit stop2,
      input int spike_bit);
    set_cfg(div, nbits, par_en, even, two);
    build_frame(nbits, par_en, even, two, data, flip, stop1, stop2);
    drive_line(div, -1, spike_bit, div - div / 2);
    serial_i = 1'b1;
    repeat (2 * div) @(negedge clock_i);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int k;
    k = 0;
    while (!valid_o && k < budget) begin
      @(negedge clock_i);
      k++;
    end
    chk(name, int'(valid_o), 1);
  endtask

  task automatic pop;
    read_i = 1'b1;
    @(negedge clock_i);
    read_i = 1'b0;
  endtask

  function automatic int head_word();
    return int'({break_o, framing_error_o, parity_error_o, data_o});
  endfunction

  task automatic drain(input string name);
    while (exp_q.size() > 0) begin
      wait_valid({name, "_valid"}, 64);
      chk({name, "_head"}, head_word(), int'(exp_q.pop_front()));
      pop();
    end
    chk({name, "_empty"}, int'(fifo_count_o), 0);
  endtask

  initial begin
    logic [FW-1:0] w;
    int div, nb, data;
    bit pe, ev, tw, fl, s1, s2;

    // stimulus table
    vecs[0] = '{16, 8, 0, 0, 0, 'hA5, 0, 1, 1, 'h0A5, 0, 0, 0};
    vecs[1] = '{16, 7, 1, 1, 1, 'h41, 1, 1, 1, 'h041, 1, 0, 0};
    vecs[2] = '{16, 7, 1, 1, 1, 'h41, 0, 1, 0, 'h041, 0, 1, 0};
    vecs[3] = '{16, 3, 0, 0, 0, 'hFF, 0, 1, 1, 'h01F, 0, 0, 0};
    vecs[4] = '{10, 15, 1, 0, 0, 'h1AB, 0, 1, 1, 'h1AB, 0, 0, 0};
    vecs[5] = '{3, 5, 1, 1, 0, 'h15, 1, 1, 1, 'h015, 1, 0, 0};
    vecs[6] = '{2, 6, 0, 0, 1, 'h2A, 0, 1, 1, 'h02A, 0, 0, 0};
    vecs[7] = '{4, 8, 1, 0, 0, 'h00, 0, 1, 1, 'h000, 0, 0, 0};

    reset_i = 1'b1; serial_i = 1'b1; read_i = 1'b0; clear_errors_i = 1'b0;
    set_cfg(16, 8, 0, 0, 0);
    repeat (3) @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    chk("reset_outputs", int'({data_o, valid_o, parity_error_o, framing_error_o,
                               break_o, overrun_o, fifo_count_o}), 0);
    chk("reset_state", int'(state_o), 0);

    // read while empty is ignored
    pop();
    chk("empty_read_count", int'(fifo_count_o), 0);

    // directed table
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].div, vecs[i].nbits, vecs[i].par_en, vecs[i].even, vecs[i].two,
           vecs[i].data, vecs[i].flip, vecs[i].stop1, vecs[i].stop2, -1);
      wait_valid($sformatf("vec%0d_valid", i), 64);
      chk($sformatf("vec%0d_data", i), int'(data_o), vecs[i].e_data);
      chk($sformatf("vec%0d_flags", i), int'({break_o, framing_error_o, parity_error_o}),
          int'({vecs[i].e_brk, vecs[i].e_ferr, vecs[i].e_perr}));
      chk($sformatf("vec%0d_count", i), int'(fifo_count_o), 1);
      pop();
      chk($sformatf("vec%0d_popped", i), int'(valid_o), 0);
    end

    // divider below 2 never starts a frame
    set_cfg(1, 8, 0, 0, 0);
    serial_i = 1'b0;
    repeat (20) @(negedge clock_i);
    chk("div1_state", int'(state_o), 0);
    serial_i = 1'b1;
    repeat (4) @(negedge clock_i);
    chk("div1_count", int'(fifo_count_o), 0);

    // break: line low for 12 bit times at 8N1
    set_cfg(16, 8, 0, 0, 0);
    serial_i = 1'b0;
    repeat (12 * 16) @(negedge clock_i);
    chk("brk_count_low", int'(fifo_count_o), 1);
    chk("brk_state_wait", int'(state_o), 5);
    chk("brk_head", head_word(), int'({1'b1, 1'b1, 1'b0, DW'(0)}));
    serial_i = 1'b1;
    repeat (32) @(negedge clock_i);
    chk("brk_count_high", int'(fifo_count_o), 1);
    pop();
    send(16, 8, 0, 0, 0, 'h55, 0, 1, 1, -1);
    wait_valid("brk_next_valid", 64);
    chk("brk_next_head", head_word(), 'h055);
    pop();

    // overrun: five frames into a four-deep FIFO
    for (int i = 1; i <= 5; i++) send(8, 8, 0, 0, 0, i, 0, 1, 1, -1);
    chk("ovr_count", int'(fifo_count_o), 4);
    chk("ovr_flag", int'(overrun_o), 1);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ovr_read%0d", i), head_word(), i);
      pop();
    end
    chk("ovr_empty", int'(valid_o), 0);
    chk("ovr_sticky", int'(overrun_o), 1);
    clear_errors_i = 1'b1;
    @(negedge clock_i);
    clear_errors_i = 1'b0;
    chk("ovr_cleared", int'(overrun_o), 0);

    // glitch: 3-cycle low pulse is a false start
    set_cfg(16, 8, 0, 0, 0);
    serial_i = 1'b0;
    repeat (3) @(negedge clock_i);
    serial_i = 1'b1;
    repeat (40) @(negedge clock_i);
    chk("glitch_state", int'(state_o), 0);
    chk("glitch_count", int'(fifo_count_o), 0);
    send(16, 8, 0, 0, 0, 'h3C, 0, 1, 1, -1);
    wait_valid("glitch_next_valid", 64);
    chk("glitch_next_head", head_word(), 'h03C);
    pop();

    // reset mid-DATA with a frame already queued
    send(16, 8, 0, 0, 0, 'h11, 0, 1, 1, -1);
    build_frame(8, 0, 0, 0, 'hF0, 0, 1, 1);
    drive_line(16, 4, -1, 0);
    chk("rst_mid_state", int'(state_o), 2);
    reset_i = 1'b1;
    @(negedge clock_i);
    chk("rst_mid_outputs", int'({data_o, valid_o, parity_error_o, framing_error_o,
                                 break_o, overrun_o, fifo_count_o}), 0);
    chk("rst_mid_fsm", int'(state_o), 0);
    reset_i = 1'b0;
    serial_i = 1'b1;
    repeat (40) @(negedge clock_i);
    chk("rst_quiet_count", int'(fifo_count_o), 0);
    send(16, 8, 0, 0, 0, 'hF0, 0, 1, 1, -1);
    wait_valid("rst_next_valid", 64);
    chk("rst_next_head", head_word(), 'h0F0);
    pop();

    // one-cycle spike on data bit 1 exactly at the centre sample
    send(16, 8, 0, 0, 0, 'hF0, 0, 1, 1, 2);
    wait_valid("spike_valid", 64);
`ifdef UART_RX_MAJORITY_EN
    chk("spike_head", head_word(), 'h0F0);
`else
    chk("spike_head", head_word(), 'h0F2);
`endif
    pop();

    // randomized frames against the frame-level model
    for (int i = 0; i < 30; i++) begin
      div  = $urandom_range(20, 6);
      nb   = $urandom_range(10, 4);
      pe   = bit'($urandom_range(1, 0));
      ev   = bit'($urandom_range(1, 0));
      tw   = bit'($urandom_range(1, 0));
      fl   = ($urandom_range(3, 0) == 0);
      s1   = ($urandom_range(5, 0) != 0);
      s2   = ($urandom_range(5, 0) != 0);
      data = ($urandom_range(4, 0) == 0) ? 0 : int'($urandom_range(511, 0));
      w = model_word(nb, pe, ev, tw, data, fl, s1, s2);
      exp_q.push_back(w);
      send(div, nb, pe, ev, tw, data, fl, s1, s2, -1);
      chk($sformatf("rnd%0d_count", i), int'(fifo_count_o), exp_q.size());
      if (exp_q.size() >= 3 || $urandom_range(1, 0) == 1) drain($sformatf("rnd%0d", i));
    end
    drain("rnd_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
